// File: rtl/barrel_rotator_arbiter.sv
// Round-robin arbiter that shares one right-rotator among several valid/ready requesters.
// The rotated word is registered and returned on one response channel, tagged with the requester index.

module barrel_rotator_right #(
  parameter int WIDTH      = 8,
  parameter int WIDTH_LOG2 = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]      data,
  input  logic [WIDTH_LOG2-1:0] rotation,
  output logic [WIDTH-1:0]      result
);

  logic [WIDTH-1:0]   stage;
  logic [2*WIDTH-1:0] wide;
  int unsigned        step_amount;

  // Stage k rotates by 2^k mod WIDTH, so non-power-of-two widths stay correct.
  always_comb begin
    stage       = data;
    wide        = '0;
    step_amount = 0;
    for (int unsigned k = 0; k < WIDTH_LOG2; k++) begin
      step_amount = (32'd1 << k) % WIDTH;
      wide        = {stage, stage} >> step_amount;
      if (rotation[k]) begin
        stage = wide[WIDTH-1:0];
      end
    end
    result = stage;
  end

endmodule

module barrel_rotator_arbiter #(
  parameter int WIDTH           = 8,
  parameter int WIDTH_LOG2      = $clog2(WIDTH),
  parameter int REQUESTERS      = 4,
  parameter int REQUESTERS_LOG2 = $clog2(REQUESTERS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            request_valid,
  output logic [REQUESTERS-1:0]            request_ready,
  input  logic [REQUESTERS*WIDTH-1:0]      request_data,
  input  logic [REQUESTERS*WIDTH_LOG2-1:0] request_rotation,
  output logic                             response_valid,
  input  logic                             response_ready,
  output logic [WIDTH-1:0]                 response_data,
  output logic [REQUESTERS_LOG2-1:0]       response_index
);

  logic [REQUESTERS_LOG2-1:0] pointer;
  logic [REQUESTERS_LOG2-1:0] pointer_next;
  logic [REQUESTERS_LOG2-1:0] grant_index;
  logic [REQUESTERS_LOG2-1:0] probe;
  logic                       grant_found;
  logic                       grant_any;
  logic                       slot_free;
  logic [WIDTH-1:0]           sel_data;
  logic [WIDTH_LOG2-1:0]      sel_rotation;
  logic [WIDTH_LOG2-1:0]      rotation_mod;
  logic [WIDTH-1:0]           rotated;

  assign slot_free = !response_valid || response_ready;

  // Search upward from the pointer, wrapping at REQUESTERS-1 back to 0.
  always_comb begin
    grant_found = 1'b0;
    grant_index = '0;
    probe       = '0;
    for (int unsigned off = 0; off < REQUESTERS; off++) begin
      probe = REQUESTERS_LOG2'((32'(pointer) + off) % REQUESTERS);
      if (!grant_found && request_valid[probe]) begin
        grant_found = 1'b1;
        grant_index = probe;
      end
    end
    grant_any = grant_found && slot_free;
  end

  always_comb begin
    request_ready = '0;
    if (grant_any) begin
      request_ready[grant_index] = 1'b1;
    end
  end

  always_comb begin
    sel_data     = '0;
    sel_rotation = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (grant_index == REQUESTERS_LOG2'(i)) begin
        sel_data     = request_data[i*WIDTH +: WIDTH];
        sel_rotation = request_rotation[i*WIDTH_LOG2 +: WIDTH_LOG2];
      end
    end
  end

  assign rotation_mod = WIDTH_LOG2'(32'(sel_rotation) % WIDTH);

  assign pointer_next = (grant_index == REQUESTERS_LOG2'(REQUESTERS - 1)) ? '0
                                                                          : grant_index + 1'b1;

  barrel_rotator_right #(
    .WIDTH      (WIDTH),
    .WIDTH_LOG2 (WIDTH_LOG2)
  ) u_rotator (
    .data     (sel_data),
    .rotation (rotation_mod),
    .result   (rotated)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      response_valid <= 1'b0;
      response_data  <= '0;
      response_index <= '0;
      pointer        <= '0;
    end else if (grant_any) begin
      response_valid <= 1'b1;
      response_data  <= rotated;
      response_index <= grant_index;
      pointer        <= pointer_next;
    end else if (response_ready) begin
      response_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barrel_rotator_arbiter.sv
// Scoreboard bench for barrel_rotator_arbiter: directed vectors with hand-computed results,
// a 6-bit instance for modulo rotation, and a random traffic phase.

module tb_barrel_rotator_arbiter;

  localparam int W  = 8;
  localparam int WL = 3;
  localparam int R  = 4;
  localparam int RL = 2;

  logic          clock;
  logic          reset;
  logic [R-1:0]  request_valid;
  logic [R-1:0]  request_ready;
  logic [R*W-1:0]  request_data;
  logic [R*WL-1:0] request_rotation;
  logic          response_valid;
  logic          response_ready;
  logic [W-1:0]  response_data;
  logic [RL-1:0] response_index;

  logic [1:0]  v6, r6;
  logic [11:0] d6;
  logic [5:0]  rot6;
  logic        rv6, rr6;
  logic [5:0]  rd6;
  logic [0:0]  ri6;

  typedef struct packed {
    logic [RL-1:0] idx;
    logic [W-1:0]  data;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  logic [W-1:0] t2_exp [R];
  bit          pend  [R];
  int unsigned waitc [R];

  barrel_rotator_arbiter #(
    .WIDTH           (W),
    .WIDTH_LOG2      (WL),
    .REQUESTERS      (R),
    .REQUESTERS_LOG2 (RL)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (request_valid),
    .request_ready    (request_ready),
    .request_data     (request_data),
    .request_rotation (request_rotation),
    .response_valid   (response_valid),
    .response_ready   (response_ready),
    .response_data    (response_data),
    .response_index   (response_index)
  );

  barrel_rotator_arbiter #(
    .WIDTH           (6),
    .WIDTH_LOG2      (3),
    .REQUESTERS      (2),
    .REQUESTERS_LOG2 (1)
  ) dut6 (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (v6),
    .request_ready    (r6),
    .request_data     (d6),
    .request_rotation (rot6),
    .response_valid   (rv6),
    .response_ready   (rr6),
    .response_data    (rd6),
    .response_index   (ri6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every accepted response is popped and compared against the scoreboard.
  always @(negedge clock) begin
    if (!reset && response_valid && response_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL response_extra: got idx=%0d data=%h, required no response",
                 response_index, response_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (response_index !== mon_e.idx || response_data !== mon_e.data) begin
          mismatched++;
          $display("FAIL response: got idx=%0d data=%h, required idx=%0d data=%h",
                   response_index, response_data, mon_e.idx, mon_e.data);
        end
      end
    end
  end

  function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input int unsigned r);
    logic [W-1:0] o;
    int unsigned  s;
    s = r % W;
    for (int unsigned j = 0; j < W; j++) o[j] = d[(j + s) % W];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic at_negedge;
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [WL-1:0] r);
    request_data[i*W +: W]       = d;
    request_rotation[i*WL +: WL] = r;
  endtask

  task automatic push(input int i, input logic [W-1:0] d);
    exp_q.push_back({RL'(i), d});
  endtask

  task automatic drain(input string name);
    int unsigned k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clock);
      k++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: got %0d results outstanding, required 0", name, exp_q.size());
    end
    next_cycle();
  endtask

  initial begin
    reset            = 1'b1;
    request_valid    = '0;
    request_data     = '0;
    request_rotation = '0;
    response_ready   = 1'b0;
    v6 = '0; d6 = '0; rot6 = '0; rr6 = 1'b1;
    t2_exp[0] = 8'hC0; t2_exp[1] = 8'hF0; t2_exp[2] = 8'h0F; t2_exp[3] = 8'h02;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    at_negedge();
    chk("reset_valid", response_valid, 0);
    chk("reset_data", response_data, 0);
    chk("reset_index", response_index, 0);
    chk("reset_ready", request_ready, 0);

    // Single request after reset.
    next_cycle();
    set_req(0, 8'hB4, 3'd3);
    request_valid  = 4'b0001;
    response_ready = 1'b1;
    push(0, 8'h96);
    at_negedge();
    chk("t1_ready", request_ready, 4'b0001);
    next_cycle();
    request_valid = '0;
    at_negedge();
    chk("t1_valid", response_valid, 1);
    drain("t1_drain");

    // Round robin with all requesters valid, pointer restarted at 0.
    reset = 1'b1;
    #1 reset = 1'b0;
    set_req(0, 8'h81, 3'd1);
    set_req(1, 8'h0F, 3'd4);
    set_req(2, 8'h3C, 3'd2);
    set_req(3, 8'h01, 3'd7);
    request_valid = '1;
    for (int k = 0; k < 6; k++) begin
      push(k % R, t2_exp[k % R]);
      at_negedge();
      chk("t2_ready", request_ready, 32'd1 << (k % R));
      if (k > 0) chk("t2_valid", response_valid, 1);
      next_cycle();
    end
    request_valid = '0;
    drain("t2_drain");

    // Back-pressure: pointer is at 2.
    response_ready = 1'b0;
    request_valid  = '1;
    push(2, 8'h0F);
    at_negedge();
    chk("t3_first_ready", request_ready, 4'b0100);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      at_negedge();
      chk("t3_hold_ready", request_ready, 0);
      chk("t3_hold_data", response_data, 8'h0F);
      chk("t3_hold_index", response_index, 2);
      chk("t3_hold_valid", response_valid, 1);
      next_cycle();
    end
    response_ready = 1'b1;
    push(3, 8'h02);
    at_negedge();
    chk("t3_resume_ready", request_ready, 4'b1000);
    next_cycle();
    request_valid = '0;
    drain("t3_drain");

    // Rotation edges.
    set_req(0, 8'hA5, 3'd0);
    request_valid = 4'b0001;
    push(0, 8'hA5);
    at_negedge();
    chk("t4_rot0_ready", request_ready, 4'b0001);
    next_cycle();
    set_req(1, 8'h01, 3'd7);
    request_valid = 4'b0010;
    push(1, 8'h02);
    at_negedge();
    chk("t4_rot7_ready", request_ready, 4'b0010);
    next_cycle();
    request_valid = '0;
    drain("t4_drain");

    // Six-bit instance: amounts 7 and 6 reduce to 1 and 0.
    d6[5:0]   = 6'b000001;
    rot6[2:0] = 3'd7;
    v6        = 2'b01;
    at_negedge();
    chk("w6_ready", r6, 2'b01);
    next_cycle();
    d6[11:6]  = 6'b000011;
    rot6[5:3] = 3'd6;
    v6        = 2'b10;
    at_negedge();
    chk("w6_rot7_data", rd6, 6'b100000);
    chk("w6_rot7_index", ri6, 0);
    chk("w6_ready2", r6, 2'b10);
    next_cycle();
    v6 = '0;
    at_negedge();
    chk("w6_rot6_data", rd6, 6'b000011);
    chk("w6_rot6_index", ri6, 1);
    chk("w6_valid", rv6, 1);

    // Reset while a result is held; the held result is dropped.
    next_cycle();
    response_ready = 1'b0;
    set_req(2, 8'h3C, 3'd2);
    request_valid = 4'b0100;
    push(2, 8'h0F);
    at_negedge();
    chk("t5_ready", request_ready, 4'b0100);
    next_cycle();
    request_valid = '0;
    at_negedge();
    chk("t5_held", response_valid, 1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_rst_valid", response_valid, 0);
    chk("t5_rst_data", response_data, 0);
    chk("t5_rst_index", response_index, 0);
    next_cycle();
    reset          = 1'b0;
    response_ready = 1'b1;
    set_req(0, 8'h81, 3'd1);
    request_valid  = '1;
    push(0, 8'hC0);
    at_negedge();
    chk("t5_after_ready", request_ready, 4'b0001);
    next_cycle();
    request_valid = '0;
    drain("t5_drain");

    // Random traffic; expected results pushed on each observed request transfer.
    for (int i = 0; i < R; i++) begin
      pend[i]  = 1'b0;
      waitc[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      for (int i = 0; i < R; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          set_req(i, W'($urandom), WL'($urandom));
        end
        request_valid[i] = pend[i];
      end
      response_ready = ($urandom_range(3, 0) != 0);
      at_negedge();
      chk("rnd_onehot", 32'($onehot0(request_ready)), 1);
      chk("rnd_subset", request_ready & ~request_valid, 0);
      for (int i = 0; i < R; i++) begin
        if (request_valid[i] && request_ready[i]) begin
          push(i, rotr(request_data[i*W +: W], request_rotation[i*WL +: WL]));
          chk("rnd_fair", 32'(waitc[i] <= R - 1), 1);
          for (int j = 0; j < R; j++) begin
            if (j != i && request_valid[j]) waitc[j]++;
          end
          waitc[i] = 0;
          pend[i]  = 1'b0;
        end
      end
    end
    next_cycle();
    request_valid  = '0;
    response_ready = 1'b1;
    drain("rnd_drain");
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
